// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisors for a 12 MHz system clock and a small
// elaboration-time helper used to size counters.
package uart_pkg;

    localparam int unsigned B115200 = 32'd104;
    localparam int unsigned B57600  = 32'd208;
    localparam int unsigned B38400  = 32'd313;
    localparam int unsigned B19200  = 32'd625;
    localparam int unsigned B9600   = 32'd1250;
    localparam int unsigned B4800   = 32'd2500;
    localparam int unsigned B2400   = 32'd5000;
    localparam int unsigned B1200   = 32'd10000;
    localparam int unsigned B300    = 32'd40000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/baud_div_if.sv
// Run-enable / tick pair between the UART frame controller and the baud divider.
interface baud_div_if;
    logic clk_en;
    logic pulse_out;

    modport master (output clk_en, input pulse_out);
    modport slave  (input clk_en, output pulse_out);
endinterface

// File: rtl/baud_div.sv
// Programmable clock-enable divider: one-cycle tick every DIVISOR enabled cycles,
// with a separately configurable delay to the first tick after enable.
module baud_div
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR     = B115200,
    parameter int unsigned FIRST_DELAY = B115200
) (
    input  logic        clk_in,
    input  logic        rstn,
    baud_div_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(max_u(DIVISOR, FIRST_DELAY));

    if (DIVISOR < 32'd2) begin : g_bad_divisor
        $error("baud_div: DIVISOR must be >= 2");
    end
    if (FIRST_DELAY < 32'd1) begin : g_bad_first_delay
        $error("baud_div: FIRST_DELAY must be >= 1");
    end

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIVISOR - 32'd1);
    localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_DELAY - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic             first_r;
    logic             pulse_r;
    logic             at_limit_s;

    // Terminal-count detect; the first period after enable uses its own limit.
    always_comb begin
        at_limit_s = 1'b0;
        if (first_r) begin
            at_limit_s = (cnt_r == FIRST_LAST);
        end else begin
            at_limit_s = (cnt_r == DIV_LAST);
        end
    end

    // Period counter, first-period flag and registered tick; disable clears all phase.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            cnt_r   <= '0;
            first_r <= 1'b1;
            pulse_r <= 1'b0;
        end else if (!bus.clk_en) begin
            cnt_r   <= '0;
            first_r <= 1'b1;
            pulse_r <= 1'b0;
        end else if (at_limit_s) begin
            cnt_r   <= '0;
            first_r <= 1'b0;
            pulse_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            first_r <= first_r;
            pulse_r <= 1'b0;
        end
    end

    assign bus.pulse_out = pulse_r;

endmodule

// File: tb/tb_baud_div.sv
// Directed bench for baud_div: four parameterisations driven from one linear
// sequence, expected tick positions computed from the enabled-edge count.
module tb_baud_div;

    logic clk_in = 1'b0;
    logic rstn   = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_in = ~clk_in;

    baud_div_if if_a ();
    baud_div_if if_b ();
    baud_div_if if_c ();
    baud_div_if if_d ();

    baud_div #(.DIVISOR(104), .FIRST_DELAY(104)) u_a (.clk_in(clk_in), .rstn(rstn), .bus(if_a.slave));
    baud_div #(.DIVISOR(10),  .FIRST_DELAY(3))   u_b (.clk_in(clk_in), .rstn(rstn), .bus(if_b.slave));
    baud_div #(.DIVISOR(10),  .FIRST_DELAY(10))  u_c (.clk_in(clk_in), .rstn(rstn), .bus(if_c.slave));
    baud_div #(.DIVISOR(2),   .FIRST_DELAY(1))   u_d (.clk_in(clk_in), .rstn(rstn), .bus(if_d.slave));

    task automatic check(input string tag, input int n, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (n=%0d): observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic tick_at(input int n, input int first, input int div);
        return (n >= first) && (((n - first) % div) == 0);
    endfunction

    initial begin
        if_a.clk_en = 1'b0;
        if_b.clk_en = 1'b0;
        if_c.clk_en = 1'b0;
        if_d.clk_en = 1'b0;

        // reset state
        #12;
        check("rst_pulse_a", 0, if_a.pulse_out, 1'b0);
        check("rst_pulse_d", 0, if_d.pulse_out, 1'b0);
        check("rst_cnt_a",   0, (u_a.cnt_r == '0), 1'b1);
        check("rst_first_a", 0, u_a.first_r, 1'b1);
        rstn = 1'b1;

        // held disabled: no ticks, counter parked at zero
        for (int n = 1; n <= 500; n++) begin
            step();
            check("idle_pulse_a", n, if_a.pulse_out, 1'b0);
            check("idle_pulse_b", n, if_b.pulse_out, 1'b0);
            check("idle_cnt_a",   n, (u_a.cnt_r == '0), 1'b1);
        end

        // 104/104: first tick after e104, then every 104 for 10 more periods
        if_a.clk_en = 1'b1;
        for (int n = 1; n <= 104 + 10 * 104 + 3; n++) begin
            step();
            check("a_tick", n, if_a.pulse_out, tick_at(n, 104, 104));
        end
        if_a.clk_en = 1'b0;

        // 10/3: ticks after e3, e13, e23, e33
        if_b.clk_en = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            step();
            check("b_tick", n, if_b.pulse_out, tick_at(n, 3, 10));
        end
        // disable in the cycle the tick is showing: it stays, next edge clears it
        if_b.clk_en = 1'b0;
        check("b_drop_hold", 33, if_b.pulse_out, 1'b1);
        step();
        check("b_drop_clear", 34, if_b.pulse_out, 1'b0);
        check("b_drop_cnt",   34, (u_b.cnt_r == '0), 1'b1);
        check("b_drop_first", 34, u_b.first_r, 1'b1);

        // 10/10: abort after 6 edges, idle 5, restart from a full first delay
        if_c.clk_en = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            check("c_pre_abort", n, if_c.pulse_out, 1'b0);
        end
        if_c.clk_en = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step();
            check("c_aborted", n, if_c.pulse_out, 1'b0);
        end
        if_c.clk_en = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            step();
            check("c_restart", n, if_c.pulse_out, tick_at(n, 10, 10));
        end
        if_c.clk_en = 1'b0;

        // 2/1: ticks after e1, e3, e5, e7 alternating
        if_d.clk_en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            check("d_tick", n, if_d.pulse_out, tick_at(n, 1, 2));
        end
        if_d.clk_en = 1'b0;
        step();
        step();

        // asynchronous reset mid-period while a tick is showing
        if_c.clk_en = 1'b1;
        if_d.clk_en = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
        end
        check("pre_rst_d_tick", 3, if_d.pulse_out, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_d_pulse", 0, if_d.pulse_out, 1'b0);
        check("async_rst_c_cnt",   0, (u_c.cnt_r == '0), 1'b1);
        check("async_rst_d_first", 0, u_d.first_r, 1'b1);
        step();
        check("in_rst_d_pulse", 0, if_d.pulse_out, 1'b0);
        check("in_rst_c_cnt",   0, (u_c.cnt_r == '0), 1'b1);
        #2;
        rstn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            check("post_rst_c", n, if_c.pulse_out, tick_at(n, 10, 10));
            check("post_rst_d", n, if_d.pulse_out, tick_at(n, 1, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/baud_div.md
# baud_div

Programmable clock-enable divider: while enabled, it emits a one-clock-cycle pulse at a fixed baud period derived from the system clock. It is the bit-timing tick source inside the UART transmitter: it is enabled for the duration of a frame and held idle between frames. The first tick after enable has its own configurable delay, so the first data shift lands a full bit period after the start bit is loaded.

## Interface
- `DIVISOR`, default 104: period between pulses in `clk_in` cycles (115200 baud at 12 MHz); must be ≥ 2.
- `FIRST_DELAY`, default 104: enabled cycles from enable to the first pulse; must be ≥ 1. The UART instantiates both parameters with the same baud constant.
- `clk_in`  input  1  system clock; all logic on the rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `clk_en`  input  1  run enable; low holds the divider cleared.
- `pulse_out`  output  1  registered one-cycle tick.

## Operation
- Internal counter width: clog2(max(DIVISOR, FIRST_DELAY)). Internal flag `first` selects the current period limit:
  - limit = FIRST_DELAY while `first` = 1;
  - limit = DIVISOR while `first` = 0.
- `clk_en` = 0 at a rising edge:
  - counter ← 0;
  - `first` ← 1;
  - `pulse_out` ← 0.
- `clk_en` = 1 and counter == limit−1:
  - counter ← 0;
  - `first` ← 0;
  - `pulse_out` ← 1.
- `clk_en` = 1 otherwise:
  - counter ← counter+1;
  - `pulse_out` ← 0.
- Dropping `clk_en` mid-period aborts that period. Re-enabling restarts with FIRST_DELAY, with no residual phase.
- Elaboration error if DIVISOR < 2 or FIRST_DELAY < 1.

## Timing
- Reset values: `pulse_out` = 0, counter = 0, `first` = 1. Reset is asynchronous and may assert at any time, including mid-period; after release the divider behaves as if freshly disabled.
- Number the rising edges at which `clk_en` = 1 as e1, e2, ….
  - `pulse_out` is high for exactly one cycle, following edge e(FIRST_DELAY).
  - Subsequent pulses follow edges e(FIRST_DELAY + k·DIVISOR), k = 1, 2, ….
- `pulse_out` is never high for two consecutive cycles, given DIVISOR ≥ 2.
  - The FIRST_DELAY = 1 case yields a pulse after e1, then every DIVISOR cycles.
- If `clk_en` falls in the same cycle a pulse is being registered, that pulse still appears (it was registered at the prior edge). The next edge clears it.
- No combinational path from inputs to `pulse_out`.

## Structure
- Shared package `uart_pkg`: baud divisor constants for a 12 MHz clock:
  - B115200 = 104
  - B57600 = 208
  - B38400 = 313
  - B19200 = 625
  - B9600 = 1250
  - B4800 = 2500
  - B2400 = 5000
  - B1200 = 10000
  - B300 = 40000
- Both the UART transmitter and this block import these constants.
- Single flat module; no sub-modules.

## Test plan
- Reset, clk_en held 0 for 500 cycles → `pulse_out` stays 0; counter stays 0.
- DIVISOR = 104, FIRST_DELAY = 104, clk_en raised and held → first pulse the cycle after the 104th enabled edge. Then exactly one pulse per 104 cycles for ≥ 10 periods, each 1 cycle wide.
- DIVISOR = 10, FIRST_DELAY = 3 → pulses after enabled edges 3, 13, 23, 33.
- DIVISOR = 10, FIRST_DELAY = 10:
  - drop clk_en after 6 enabled edges, re-raise 5 cycles later;
  - required: first pulse after the 10th new enabled edge, no pulse from the aborted period.
- Assert rstn low asynchronously between clock edges mid-period:
  - `pulse_out` goes 0 immediately;
  - after release with clk_en = 1, first pulse after FIRST_DELAY enabled edges.
- DIVISOR = 2, FIRST_DELAY = 1 → pulses after enabled edges 1, 3, 5, 7, alternating high and low.
